counter_bank: RTL and testbench

Multi-channel event/cycle counter bank for the measurement core. It is the parametrised successor of the single counter: CHANNELS independent WIDTH-bit counters, each with its own run control and compare register. Per-channel modes are free-run, one-shot, auto-reload and saturate. The block adds sticky overflow flags, single-cycle compare-match pulses and a bank-wide simultaneous snapshot, so the host can read all channels coherently while counting continues.

---
 rtl/counter_bank.sv | 133 +++++++++++++
 tb/tb_counter_bank.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_bank.sv
// counter_bank: CHANNELS independent WIDTH-bit counters. Each channel has
// its own run control, compare register, sticky overflow flag and
// compare-match pulse. A shared capture strobe snapshots every channel at once.
module counter_bank #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned CHANNELS = 4
) (
   input  logic                         clk,
   input  logic                         sysrst_n,
   input  logic [CHANNELS-1:0]          start,
   input  logic [CHANNELS-1:0]          stop,
   input  logic [CHANNELS-1:0]          clear,
   input  logic [CHANNELS-1:0]          load,
   input  logic [CHANNELS-1:0]          count,
   input  logic [CHANNELS*WIDTH-1:0]    ivalue,
   input  logic [CHANNELS*WIDTH-1:0]    cmp,
   input  logic [CHANNELS*2-1:0]        mode,
   input  logic [CHANNELS-1:0]          ovf_clr,
   input  logic                         capture,
   output logic [CHANNELS*WIDTH-1:0]    value,
   output logic [CHANNELS*WIDTH-1:0]    snap,
   output logic [CHANNELS-1:0]          running,
   output logic [CHANNELS-1:0]          match,
   output logic [CHANNELS-1:0]          ovf
);

   typedef enum logic [1:0] {
      MODE_FREE    = 2'b00,
      MODE_ONESHOT = 2'b01,
      MODE_RELOAD  = 2'b10,
      MODE_SAT     = 2'b11
   } mode_t;

   // Per-channel views of the packed buses
   logic [CHANNELS-1:0][WIDTH-1:0] iv_a, cmp_a;
   logic [CHANNELS-1:0][1:0]       mode_a;

   logic [CHANNELS-1:0][WIDTH-1:0] val_q, val_d, snap_q, snap_d, nxt;
   logic [CHANNELS-1:0]            run_q, run_d, match_q, match_d;
   logic [CHANNELS-1:0]            ovf_q, ovf_d, ovf_set, inc, os_hit;

   assign iv_a   = ivalue;
   assign cmp_a  = cmp;
   assign mode_a = mode;

   // Next-state for run state, value, match and overflow of every channel
   always_comb begin
      val_d   = val_q;
      run_d   = run_q;
      match_d = '0;
      ovf_set = '0;
      os_hit  = '0;
      nxt     = '0;
      inc     = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         nxt[i] = val_q[i] + WIDTH'(1);
         inc[i] = count[i] & run_q[i];

         if (clear[i]) begin
            val_d[i] = '0;
         end else if (load[i]) begin
            val_d[i] = iv_a[i];
         end else if (inc[i]) begin
            unique case (mode_t'(mode_a[i]))
               MODE_FREE: begin
                  val_d[i]   = nxt[i];
                  ovf_set[i] = (nxt[i] == '0);
               end
               MODE_ONESHOT: begin
                  val_d[i]   = nxt[i];
                  ovf_set[i] = (nxt[i] == '0);
                  match_d[i] = (nxt[i] == cmp_a[i]);
                  os_hit[i]  = (nxt[i] == cmp_a[i]);
               end
               MODE_RELOAD: begin
                  if (nxt[i] == cmp_a[i]) begin
                     val_d[i]   = iv_a[i];
                     match_d[i] = 1'b1;
                  end else begin
                     val_d[i]   = nxt[i];
                     ovf_set[i] = (nxt[i] == '0);
                  end
               end
               MODE_SAT: begin
                  if (val_q[i] == '1) begin
                     ovf_set[i] = 1'b1;
                  end else begin
                     val_d[i]   = nxt[i];
                     match_d[i] = (nxt[i] == cmp_a[i]);
                  end
               end
               default: ;
            endcase
         end

         unique case ({start[i], stop[i]})
            2'b11:   run_d[i] = ~run_q[i];
            2'b10:   run_d[i] = 1'b1;
            2'b01:   run_d[i] = 1'b0;
            default: run_d[i] = run_q[i];
         endcase
         // A one-shot match halts the channel unless start (alone or as a
         // toggle) is asserted in the same cycle, which keeps it running.
         if (os_hit[i]) run_d[i] = start[i];
      end
      ovf_d  = ovf_set | (ovf_q & ~ovf_clr);
      snap_d = capture ? val_q : snap_q;
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk or negedge sysrst_n) begin
      if (!sysrst_n) begin
         val_q   <= '0;
         snap_q  <= '0;
         run_q   <= '0;
         match_q <= '0;
         ovf_q   <= '0;
      end else begin
         val_q   <= val_d;
         snap_q  <= snap_d;
         run_q   <= run_d;
         match_q <= match_d;
         ovf_q   <= ovf_d;
      end
   end

   assign value   = val_q;
   assign snap    = snap_q;
   assign running = run_q;
   assign match   = match_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_counter_bank.sv
// Directed self-checking bench for counter_bank at WIDTH=4, CHANNELS=4.
module tb_counter_bank;

   localparam int unsigned W = 4;
   localparam int unsigned C = 4;

   logic           clk = 1'b0;
   logic           sysrst_n;
   logic [C-1:0]   start, stop, clear, load, count, ovf_clr;
   logic [C*W-1:0] ivalue, cmp;
   logic [C*2-1:0] mode;
   logic           capture;
   logic [C*W-1:0] value, snap;
   logic [C-1:0]   running, match, ovf;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   counter_bank #(.WIDTH(W), .CHANNELS(C)) dut (
      .clk(clk), .sysrst_n(sysrst_n), .start(start), .stop(stop),
      .clear(clear), .load(load), .count(count), .ivalue(ivalue),
      .cmp(cmp), .mode(mode), .ovf_clr(ovf_clr), .capture(capture),
      .value(value), .snap(snap), .running(running), .match(match),
      .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Advance one rising edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] val(input int unsigned ch);
      return value[ch*W +: W];
   endfunction

   function automatic logic [W-1:0] snp(input int unsigned ch);
      return snap[ch*W +: W];
   endfunction

   initial begin
      logic [W-1:0] rl_seq [8];
      rl_seq = '{4'd3, 4'd4, 4'd5, 4'd2, 4'd3, 4'd4, 4'd5, 4'd2};

      sysrst_n = 1'b0;
      {start, stop, clear, load, count, ovf_clr} = '0;
      ivalue = '0; cmp = '0; mode = '0; capture = 1'b0;
      #12;
      check("rst_value",   value,   0);
      check("rst_snap",    snap,    0);
      check("rst_running", running, 0);
      check("rst_match",   match,   0);
      check("rst_ovf",     ovf,     0);
      sysrst_n = 1'b1;
      step();

      // ch0 free-run: wrap and sticky overflow
      start[0] = 1'b1; count[0] = 1'b1;
      step();
      start[0] = 1'b0;
      check("fr_run", running[0], 1);
      check("fr_v0",  val(0), 0);
      for (int k = 1; k <= 17; k++) begin
         step();
         check("fr_val", val(0), k % 16);
         check("fr_ovf", ovf[0], (k >= 16) ? 1 : 0);
      end
      ovf_clr[0] = 1'b1;
      step();
      ovf_clr[0] = 1'b0;
      check("fr_clr_val", val(0), 2);
      check("fr_clr_ovf", ovf[0], 0);
      for (int k = 0; k < 13; k++) step();
      check("fr_15", val(0), 15);
      check("fr_15_ovf", ovf[0], 0);
      ovf_clr[0] = 1'b1;
      step();
      ovf_clr[0] = 1'b0;
      check("fr_setwins_val", val(0), 0);
      check("fr_setwins_ovf", ovf[0], 1);
      stop[0] = 1'b1;
      step();
      stop[0] = 1'b0;
      check("fr_stop_val", val(0), 1);
      check("fr_stop_run", running[0], 0);
      step();
      check("fr_hold", val(0), 1);
      count[0] = 1'b0;

      // ch1 one-shot, cmp=5
      mode[3:2] = 2'b01; cmp[7:4] = 4'd5;
      start[1] = 1'b1; count[1] = 1'b1;
      step();
      start[1] = 1'b0;
      check("os_v0", val(1), 0);
      for (int k = 1; k <= 5; k++) begin
         step();
         check("os_val",   val(1),     k);
         check("os_match", match[1],   (k == 5) ? 1 : 0);
         check("os_run",   running[1], (k == 5) ? 0 : 1);
      end
      step();
      check("os_hold",   val(1),   5);
      check("os_match0", match[1], 0);
      start[1] = 1'b1; stop[1] = 1'b1;
      step();
      start[1] = 1'b0; stop[1] = 1'b0;
      check("os_toggle_run", running[1], 1);
      check("os_toggle_val", val(1), 5);
      step();
      check("os_resume", val(1), 6);
      stop[1] = 1'b1;
      step();
      stop[1] = 1'b0; count[1] = 1'b0;
      check("os_stop_run", running[1], 0);

      // ch2 auto-reload, ivalue=2, cmp=6
      mode[5:4] = 2'b10; ivalue[11:8] = 4'd2; cmp[11:8] = 4'd6;
      load[2] = 1'b1; start[2] = 1'b1; count[2] = 1'b1;
      step();
      load[2] = 1'b0; start[2] = 1'b0;
      check("rl_load", val(2), 2);
      check("rl_load_match", match[2], 0);
      for (int k = 0; k < 8; k++) begin
         step();
         check("rl_val",   val(2),   rl_seq[k]);
         check("rl_match", match[2], (rl_seq[k] == 4'd2) ? 1 : 0);
      end
      check("rl_ovf", ovf[2], 0);
      stop[2] = 1'b1; count[2] = 1'b0;
      step();
      stop[2] = 1'b0;

      // ch3 saturate, cmp=10
      mode[7:6] = 2'b11; cmp[15:12] = 4'd10; ivalue[15:12] = 4'd13;
      load[3] = 1'b1; start[3] = 1'b1; count[3] = 1'b1;
      step();
      load[3] = 1'b0; start[3] = 1'b0;
      check("sat_load", val(3), 13);
      step();
      check("sat_14", val(3), 14);
      step();
      check("sat_15", val(3), 15);
      check("sat_15_ovf", ovf[3], 0);
      step();
      check("sat_hold", val(3), 15);
      check("sat_ovf",  ovf[3], 1);
      clear[3] = 1'b1;
      step();
      check("sat_clear", val(3), 0);
      check("sat_clear_ovf", ovf[3], 1);
      load[3] = 1'b1;
      step();
      check("sat_clr_ld", val(3), 0);
      clear[3] = 1'b0; ivalue[15:12] = 4'd10;
      step();
      check("sat_ld_cmp", val(3), 10);
      check("sat_ld_nomatch", match[3], 0);
      ivalue[15:12] = 4'd9;
      step();
      load[3] = 1'b0;
      check("sat_ld9", val(3), 9);
      step();
      check("sat_10", val(3), 10);
      check("sat_match", match[3], 1);
      step();
      check("sat_11", val(3), 11);
      check("sat_match_end", match[3], 0);

      // capture with simultaneous clear on ch0
      #2 sysrst_n = 1'b0;
      #2 sysrst_n = 1'b1;
      {start, stop, clear, load, count, ovf_clr} = '0;
      mode = '0; cmp = '0; ivalue = '0;
      step();
      start = 4'b1111;
      step();
      start = 4'b0000;
      count = 4'b0011;
      repeat (3) step();
      count = 4'b0101;
      repeat (2) step();
      capture = 1'b1; clear[0] = 1'b1; count = 4'b0111;
      step();
      capture = 1'b0; clear[0] = 1'b0;
      check("cap_snap0", snp(0), 5);
      check("cap_snap1", snp(1), 3);
      check("cap_snap2", snp(2), 2);
      check("cap_snap3", snp(3), 0);
      check("cap_val0",  val(0), 0);
      check("cap_val1",  val(1), 4);
      check("cap_val2",  val(2), 3);
      step();
      check("cap_hold0", snp(0), 5);
      check("cap_next0", val(0), 1);

      // asynchronous reset between edges
      #3 sysrst_n = 1'b0;
      #1;
      check("ar_value",   value,   0);
      check("ar_snap",    snap,    0);
      check("ar_running", running, 0);
      check("ar_match",   match,   0);
      check("ar_ovf",     ovf,     0);
      #2 sysrst_n = 1'b1;
      start = 4'b0001; count = 4'b0001;
      step();
      start = '0;
      check("ar_first_run", running[0], 1);
      check("ar_first_val", val(0), 0);
      step();
      check("ar_second_val", val(0), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
